// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the raster timing generator: 640x480@60 defaults,
// the reloadable timing bundle and its legality rule.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_640     = 640;
  localparam int H_SYNC_START_640 = 656;
  localparam int H_SYNC_END_640   = 752;
  localparam int H_TOTAL_640      = 800;
  localparam int V_ACTIVE_480     = 480;
  localparam int V_SYNC_START_480 = 490;
  localparam int V_SYNC_END_480   = 492;
  localparam int V_TOTAL_480      = 525;

  // Fields are sized for the widest supported counter; narrower instances
  // zero-extend into them and the unused upper bits fold away.
  localparam int TIMING_W_MAX = 16;

  typedef struct packed {
    logic [TIMING_W_MAX-1:0] h_active;
    logic [TIMING_W_MAX-1:0] h_sync_start;
    logic [TIMING_W_MAX-1:0] h_sync_end;
    logic [TIMING_W_MAX-1:0] h_total;
    logic [TIMING_W_MAX-1:0] v_active;
    logic [TIMING_W_MAX-1:0] v_sync_start;
    logic [TIMING_W_MAX-1:0] v_sync_end;
    logic [TIMING_W_MAX-1:0] v_total;
    logic                    hs_pol;
    logic                    vs_pol;
  } timing_t;

  localparam int TIMING_BITS = $bits(timing_t);

  function automatic logic timing_legal(timing_t t);
    return (t.h_total >= TIMING_W_MAX'(2))
        && (t.h_active <= t.h_sync_start)
        && (t.h_sync_start < t.h_sync_end)
        && (t.h_sync_end <= t.h_total)
        && (t.v_total >= TIMING_W_MAX'(2))
        && (t.v_active <= t.v_sync_start)
        && (t.v_sync_start < t.v_sync_end)
        && (t.v_sync_end <= t.v_total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Configuration port of the timing generator: a valid/ready offer of a full
// timing set, plus a one-cycle error pulse when an offer is rejected.
interface vga_timing_gen_if #(
  parameter int W = 11
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_h_active;
  logic [W-1:0] cfg_h_sync_start;
  logic [W-1:0] cfg_h_sync_end;
  logic [W-1:0] cfg_h_total;
  logic [W-1:0] cfg_v_active;
  logic [W-1:0] cfg_v_sync_start;
  logic [W-1:0] cfg_v_sync_end;
  logic [W-1:0] cfg_v_total;
  logic         cfg_hs_pol;
  logic         cfg_vs_pol;
  logic         cfg_err;

  modport master (
    output cfg_valid, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
           cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
           cfg_hs_pol, cfg_vs_pol,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
           cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
           cfg_hs_pol, cfg_vs_pol,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vga_delay_line.sv
// Pixel-enable gated shift register; DEPTH=0 degenerates to a wire.
// Every stage resets to rst_val so the output is defined from the first cycle.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce, rst_val};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Run-time reconfigurable raster timing generator. New timing is staged in a
// shadow set and swapped in only at a frame wrap, so a frame is never torn.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int W                = 11,
  parameter int DEF_H_ACTIVE     = H_ACTIVE_640,
  parameter int DEF_H_SYNC_START = H_SYNC_START_640,
  parameter int DEF_H_SYNC_END   = H_SYNC_END_640,
  parameter int DEF_H_TOTAL      = H_TOTAL_640,
  parameter int DEF_V_ACTIVE     = V_ACTIVE_480,
  parameter int DEF_V_SYNC_START = V_SYNC_START_480,
  parameter int DEF_V_SYNC_END   = V_SYNC_END_480,
  parameter int DEF_V_TOTAL      = V_TOTAL_480,
  parameter int DEF_HS_POL       = 0,
  parameter int DEF_VS_POL       = 0,
  parameter int SYNC_DLY         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  vga_timing_gen_if.slave  cfg_bus,
  output logic [W-1:0]     x,
  output logic [W-1:0]     y,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int TW = TIMING_W_MAX;

  localparam timing_t DEF_TIMING = '{
    h_active:     TW'(DEF_H_ACTIVE),
    h_sync_start: TW'(DEF_H_SYNC_START),
    h_sync_end:   TW'(DEF_H_SYNC_END),
    h_total:      TW'(DEF_H_TOTAL),
    v_active:     TW'(DEF_V_ACTIVE),
    v_sync_start: TW'(DEF_V_SYNC_START),
    v_sync_end:   TW'(DEF_V_SYNC_END),
    v_total:      TW'(DEF_V_TOTAL),
    hs_pol:       (DEF_HS_POL != 0),
    vs_pol:       (DEF_VS_POL != 0)
  };

  // Decode of x=0,y=0 under the default timing: {hsync, vsync, blank, line_start, frame_start}.
  localparam logic [4:0] DLY_RST = {(DEF_HS_POL == 0), (DEF_VS_POL == 0), 1'b0, 1'b1, 1'b1};

  timing_t               act;
  timing_t               cfg_in;
  logic [TIMING_BITS-1:0] shd;
  logic                  pending;
  logic                  xfer;
  logic                  cfg_ok;
  logic [TW-1:0]         x_ext;
  logic [TW-1:0]         y_ext;
  logic                  x_wrap;
  logic                  y_wrap;
  logic [4:0]            dec;
  logic [4:0]            dly_q;

  assign cfg_in = '{
    h_active:     TW'(cfg_bus.cfg_h_active),
    h_sync_start: TW'(cfg_bus.cfg_h_sync_start),
    h_sync_end:   TW'(cfg_bus.cfg_h_sync_end),
    h_total:      TW'(cfg_bus.cfg_h_total),
    v_active:     TW'(cfg_bus.cfg_v_active),
    v_sync_start: TW'(cfg_bus.cfg_v_sync_start),
    v_sync_end:   TW'(cfg_bus.cfg_v_sync_end),
    v_total:      TW'(cfg_bus.cfg_v_total),
    hs_pol:       cfg_bus.cfg_hs_pol,
    vs_pol:       cfg_bus.cfg_vs_pol
  };

  assign cfg_bus.cfg_ready = !pending;
  assign xfer   = cfg_bus.cfg_valid && !pending;
  assign cfg_ok = timing_legal(cfg_in);

  assign x_ext  = TW'(x);
  assign y_ext  = TW'(y);
  assign x_wrap = x_ext >= act.h_total - TW'(1);
  assign y_wrap = y_ext >= act.v_total - TW'(1);

  // A transfer needs pending=0, so it can never coincide with an apply: the
  // two pending writes below are mutually exclusive.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      x               <= '0;
      y               <= '0;
      act             <= DEF_TIMING;
      pending         <= 1'b0;
      cfg_bus.cfg_err <= 1'b0;
    end else begin
      cfg_bus.cfg_err <= xfer && !cfg_ok;
      if (ce) begin
        if (x_wrap) begin
          x <= '0;
          y <= y_wrap ? '0 : y + W'(1);
        end else begin
          x <= x + W'(1);
        end
        if (x_wrap && y_wrap && pending) begin
          act     <= timing_t'(shd);
          pending <= 1'b0;
        end
      end
      if (xfer && cfg_ok) pending <= 1'b1;
    end
  end

  // NOTE: the shadow set is data only, qualified by pending, so it carries no
  // reset; stale contents are never observed.
  always_ff @(posedge clk) begin
    if (xfer && cfg_ok) shd <= cfg_in;
  end

  always_comb begin
    logic in_h;
    logic in_v;
    in_h = (x_ext >= act.h_sync_start) && (x_ext < act.h_sync_end);
    in_v = (y_ext >= act.v_sync_start) && (y_ext < act.v_sync_end);
    dec  = { act.hs_pol ? in_h : !in_h,
             act.vs_pol ? in_v : !in_v,
             (x_ext >= act.h_active) || (y_ext >= act.v_active),
             (x == '0),
             (x == '0) && (y == '0) };
  end

  vga_delay_line #(
    .WIDTH (5),
    .DEPTH (SYNC_DLY)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .rst_val (DLY_RST),
    .d       (dec),
    .q       (dly_q)
  );

  assign {hsync, vsync, blank, line_start, frame_start} = dly_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, run-time reconfigurable successor to the fixed 640x480 raster timing generator.
- Produces pixel/line counters, sync, blank and line/frame strobes from a pixel clock-enable.
- Timing and sync polarity are reloadable through a valid/ready config port; new settings take effect only at a frame boundary.
- Sync/blank/strobes can be delayed by a fixed number of pixels to align with a pipelined pixel datapath.

Parameters:
- W, 11, width of x/y counters and all timing fields.
- DEF_H_ACTIVE, 640, reset horizontal active pixels.
- DEF_H_SYNC_START, 656, reset first hsync pixel.
- DEF_H_SYNC_END, 752, reset first pixel after hsync.
- DEF_H_TOTAL, 800, reset pixels per line.
- DEF_V_ACTIVE, 480, reset active lines.
- DEF_V_SYNC_START, 490, reset first vsync line.
- DEF_V_SYNC_END, 492, reset first line after vsync.
- DEF_V_TOTAL, 525, reset lines per frame.
- DEF_HS_POL, 0, reset hsync polarity (1 = active-high).
- DEF_VS_POL, 0, reset vsync polarity (1 = active-high).
- SYNC_DLY, 0, pixel delay (0..15) applied to hsync/vsync/blank/line_start/frame_start.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  pixel enable; counters and delay line advance only when 1
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config can be accepted
- cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total  in  W each  horizontal timing
- cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total  in  W each  vertical timing
- cfg_hs_pol, cfg_vs_pol  in  1 each  sync polarities
- cfg_err  out  1  one-cycle pulse: accepted config was illegal and discarded
- x  out  W  current pixel column
- y  out  W  current line
- hsync, vsync  out  1 each  sync, polarity-applied, delayed SYNC_DLY
- blank  out  1  outside active area, delayed SYNC_DLY
- line_start  out  1  high while x==0, delayed SYNC_DLY
- frame_start  out  1  high while x==0 && y==0, delayed SYNC_DLY

Behaviour:
- Reset: x=0, y=0; active timing = DEF_*; shadow empty; pending=0; cfg_ready=1; cfg_err=0.
- Reset: all delay-line stages hold the x=0,y=0 values (sync inactive, blank=0, line_start=1, frame_start=1). Any pending config is discarded.
- Counting, on ce=1:
  - If x >= h_total-1: x<=0; then y<=0 if y >= v_total-1, else y<=y+1.
  - Otherwise x<=x+1.
  - ce=0 holds all state.
- Decode (combinational on x,y and active regs):
  - in_h = h_sync_start <= x < h_sync_end; in_v likewise on y.
  - hsync = hs_pol ? in_h : !in_h; vsync likewise.
  - blank = x >= h_active || y >= v_active.
- SYNC_DLY=0: outputs are the decode directly. Otherwise each output passes through a SYNC_DLY-deep shift register that shifts only on ce=1. x/y are never delayed.
- Config handshake:
  - cfg_ready = !pending. Transfer occurs on cfg_valid && cfg_ready.
  - Legality: 2 <= total; active <= sync_start < sync_end <= total, for both H and V.
  - Legal: latch into shadow; pending<=1.
  - Illegal: do not latch; cfg_err=1 next cycle; pending stays 0.
- Apply: on the cycle with ce=1, x at wrap and y at wrap, with pending=1: active <= shadow (including polarities), pending<=0, counters->0. The new timing governs the first pixel of the next frame.
- A transfer in the same cycle as a frame wrap is applied at the following wrap, not this one.
- Polarity change takes effect in the delay line from new-frame pixels onward. Stages already in flight keep the old polarity.

Decomposition:
- Shared package/header:
  - 640x480@60 default constants.
  - Timing-field bundle (four H, four V, two polarity), with a packed-width localparam.
  - Legality-check function.
- Sub-module vga_delay_line: ce-gated, parametrised width/depth shift register with reset value input. Used once here for the 5-bit sync/blank/strobe bundle.

Test Plan:
- Reset, SYNC_DLY=0, ce=1 for 800*525 cycles:
  - hsync low exactly for x in 656..751; vsync low for y 490..491.
  - blank=1 from x=640 or y=480; frame_start once per 420000 cycles.
- ce toggling 1-of-4, 2 lines: x advances once per ce; pulse widths in clk cycles are 4x those above; nothing moves while ce=0.
- Mid-frame config load (h_total=100, hsync 80..90, v_total=50, hs_pol=1):
  - cfg_ready falls the cycle after transfer.
  - The old 800-pixel lines continue until the frame wrap.
  - Then lines are 100 pixels with hsync high at x=80..89; cfg_ready returns to 1.
- Illegal config (h_sync_start=700, h_sync_end=650): cfg_err pulses 1 cycle; timing unchanged; cfg_ready stays 1.
- SYNC_DLY=3: hsync/blank/line_start edges lag the SYNC_DLY=0 reference by exactly 3 ce-advances; x/y are identical.
- rst asserted mid-frame with a config pending: next cycle x=0, y=0, default timing, cfg_ready=1; the pending config is never applied.
